// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared defaults and helpers for the fetch/decode instruction queue
//
// Purpose : default datapath widths, the NOP word driven by an empty queue,
//           and a pointer-width helper shared by the queue and its storage.
// Ports   : none (package).
package cpu_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 32;

  // Word presented to decode when nothing is queued.
  localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;

  // Width of a pointer that indexes DEPTH entries; never narrower than 1 bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/iq_storage.sv
// rtl/iq_storage.sv - register array holding queued {instruction, PC} entries
//
// Purpose : DEPTH x WIDTH storage with one synchronous write port and one
//           asynchronous read port. The array is deliberately not reset;
//           validity is tracked by the queue's count, not by the contents.
// Ports   : clk      - rising-edge clock
//           we_i     - write enable
//           waddr_i  - write index
//           wdata_i  - write data
//           raddr_i  - read index
//           rdata_o  - read data (combinational from raddr_i)
module iq_storage
  import cpu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int AW    = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_queue.sv
// rtl/instr_queue.sv - DEPTH-entry instruction queue between fetch and decode
//
// Purpose : buffers {instruction, PC} pairs so fetch can run ahead of a
//           stalled decode; valid/ready handshake on both sides and a
//           synchronous flush for branch/jump redirects.
// Ports   : clk        - rising-edge clock
//           rst        - asynchronous active-high reset
//           flush      - discard all entries at the next edge
//           in_valid   - fetch presents in_instr/in_pc
//           in_ready   - queue can accept a word (decoded from count only)
//           in_instr   - fetched instruction
//           in_pc      - PC of the fetched instruction
//           out_valid  - head entry is valid
//           out_ready  - decode consumes the head
//           out_instr  - head instruction, NOP_WORD when empty
//           out_pc     - head PC, zero when empty
//           count      - number of occupied entries
module instr_queue
  import cpu_pkg::*;
#(
  parameter int                    DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int                    ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int                    DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = DATA_WIDTH'(DEFAULT_NOP_WORD)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      in_instr,
  input  logic [ADDR_WIDTH-1:0]      in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_instr,
  output logic [ADDR_WIDTH-1:0]      out_pc,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = DATA_WIDTH + ADDR_WIDTH;

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic          push;
  logic          pop;
  logic [EW-1:0] rd_entry;

  // in_ready depends on the registered count alone, so a full queue refuses
  // a push even while it is popping; this keeps out_ready off the fetch path.
  assign in_ready  = (count_q != FULL_COUNT);
  assign out_valid = (count_q != '0);

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      // Redirect wins over any handshake in the same cycle.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // A word pushed during a flush is dropped, so it never reaches the array.
  iq_storage #(
    .WIDTH (EW),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_storage (
    .clk     (clk),
    .we_i    (push && !flush),
    .waddr_i (wr_ptr_q),
    .wdata_i ({in_instr, in_pc}),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_entry)
  );

  assign out_instr = out_valid ? rd_entry[EW-1:ADDR_WIDTH]   : NOP_WORD;
  assign out_pc    = out_valid ? rd_entry[ADDR_WIDTH-1:0]    : '0;
  assign count     = count_q;

endmodule

// File: tb/tb_instr_queue.sv
// tb/tb_instr_queue.sv - self-checking bench for instr_queue
module tb_instr_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  logic [63:0] model_q [$];

  instr_queue #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .DEPTH      (DEPTH),
    .NOP_WORD   (NOP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the queue model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("cmp_count",     64'(count),     64'(model_q.size()));
      chk("cmp_in_ready",  64'(in_ready),  64'(model_q.size() != DEPTH));
      chk("cmp_out_valid", 64'(out_valid), 64'(model_q.size() != 0));
      chk("cmp_out_instr", 64'(out_instr), (model_q.size() != 0) ? 64'(model_q[0][63:32]) : 64'(NOP));
      chk("cmp_out_pc",    64'(out_pc),    (model_q.size() != 0) ? 64'(model_q[0][31:0])  : 64'h0);
    end
  end

  // Called just after an edge: present inputs, take the next edge, advance
  // the model by the transfer rules, and return 1 time unit after that edge.
  task automatic cycle(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    bit pu;
    bit po;
    in_valid  = iv;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else begin
      pu = iv && (model_q.size() != DEPTH);
      po = ordy && (model_q.size() != 0);
      if (po) void'(model_q.pop_front());
      if (pu) model_q.push_back({ins, pc});
    end
    #1;
  endtask

  task automatic sync_reset();
    rst = 1'b1;
    model_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_count"},     64'(count),     64'h0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'h0);
    chk({tag, "_in_ready"},  64'(in_ready),  64'h1);
    chk({tag, "_out_instr"}, 64'(out_instr), 64'(NOP));
    chk({tag, "_out_pc"},    64'(out_pc),    64'h0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset_vals("por");
    cmp_en = 1'b1;

    // Reset while words are held, then first push after reset.
    cycle(1, 32'hAAAA0001, 32'h10, 0, 0);
    cycle(1, 32'hAAAA0002, 32'h14, 0, 0);
    chk("held_count", 64'(count), 64'h2);
    sync_reset();
    chk_reset_vals("rst_held");
    cycle(1, 32'h8C220004, 32'h00400000, 0, 0);
    chk("first_out_valid", 64'(out_valid), 64'h1);
    chk("first_out_instr", 64'(out_instr), 64'h8C220004);
    chk("first_out_pc",    64'(out_pc),    64'h00400000);
    chk("first_count",     64'(count),     64'h1);

    // Fill with decode stalled.
    sync_reset();
    for (int i = 0; i < 4; i++) cycle(1, 32'h1000 + i, 32'(4 * i), 0, 0);
    chk("fill_in_ready", 64'(in_ready), 64'h0);
    chk("fill_count",    64'(count),    64'h4);
    cycle(1, 32'h1004, 32'h10, 0, 0);
    chk("fill5_count",   64'(count),    64'h4);
    chk("fill5_head_pc", 64'(out_pc),   64'h0);

    // Full: pop with a push offered; push refused.
    cycle(1, 32'h1005, 32'h14, 1, 0);
    chk("fullpop_count",    64'(count),    64'h3);
    chk("fullpop_in_ready", 64'(in_ready), 64'h1);
    chk("fullpop_head_pc",  64'(out_pc),   64'h4);

    // Streaming with pointer wrap.
    cycle(0, 0, 0, 0, 1);
    chk("flush0_count", 64'(count), 64'h0);
    for (int i = 0; i < 10; i++) begin
      cycle(1, 32'h2000 + i, 32'h100 + 32'(4 * i), 1, 0);
      chk("stream_count", 64'(count),     64'h1);
      chk("stream_pc",    64'(out_pc),    64'h100 + 64'(4 * i));
      chk("stream_instr", 64'(out_instr), 64'h2000 + 64'(i));
    end

    // Flush with count=3 and a simultaneous push and pop.
    cycle(1, 32'h3001, 32'h204, 0, 0);
    cycle(1, 32'h3002, 32'h208, 0, 0);
    chk("preflush_count", 64'(count), 64'h3);
    cycle(1, 32'hDEAD0000, 32'hDEAD0, 1, 1);
    chk("flush_count",     64'(count),     64'h0);
    chk("flush_out_valid", 64'(out_valid), 64'h0);
    chk("flush_out_instr", 64'(out_instr), 64'(NOP));
    cycle(0, 0, 0, 1, 0);
    chk("postflush_valid", 64'(out_valid), 64'h0);
    cycle(1, 32'h4444, 32'h300, 0, 0);
    chk("postflush_instr", 64'(out_instr), 64'h4444);

    // Asynchronous reset pulse between edges.
    cycle(1, 32'h5555, 32'h304, 0, 0);
    chk("prearst_count", 64'(count), 64'h2);
    #2;
    rst = 1'b1;
    model_q.delete();
    #1;
    chk_reset_vals("arst");
    rst = 1'b0;
    cycle(1, 32'h6666, 32'h400, 0, 0);
    chk("arst_push_instr", 64'(out_instr), 64'h6666);
    chk("arst_push_count", 64'(count),     64'h1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 1)), $urandom, $urandom,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_queue.md
Name: instr_queue

Overview:
- Parametrised instruction holding stage between fetch and decode.
- Successor to the single-entry instruction register: DEPTH-entry FIFO of {instruction, PC} pairs with a valid/ready handshake on both sides.
- Adds a synchronous flush for branch/jump redirect.
- Lets fetch run ahead of a stalled decode.

Parameters:
- DATA_WIDTH, 32, instruction width in bits.
- ADDR_WIDTH, 32, PC width in bits.
- DEPTH, 4, number of entries; power of two, at least 2.
- NOP_WORD, 0, value driven on out_instr when the queue is empty.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous discard of all entries.
- in_valid  in  1  fetch presents a word.
- in_ready  out  1  queue can accept a word.
- in_instr  in  DATA_WIDTH  fetched instruction.
- in_pc  in  ADDR_WIDTH  PC of the fetched instruction.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  decode consumes the head.
- out_instr  out  DATA_WIDTH  head instruction.
- out_pc  out  ADDR_WIDTH  head PC.
- count  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset rst is asynchronous and active-high.
  - During and after reset: write ptr = 0, read ptr = 0, count = 0, out_valid = 0, out_instr = NOP_WORD, out_pc = 0, in_ready = 1.
  - Storage array contents are not reset.
- Handshake rules:
  - push = in_valid && in_ready.
  - pop = out_valid && out_ready.
  - Transfers occur only on the rising clk edge.
- Combinational outputs:
  - in_ready = (count != DEPTH). Decoded from count only; no combinational path from out_ready. A full queue therefore refuses a push even in a cycle where a pop occurs.
  - out_valid = (count != 0).
  - out_instr / out_pc = storage[rd_ptr] when out_valid, else NOP_WORD / 0.
- Latency: a word pushed into an empty queue is visible on out_* in the next cycle. There is no same-cycle bypass.
- Pointers:
  - Pointer width is $clog2(DEPTH) and wraps naturally modulo DEPTH.
  - wr_ptr advances on push; rd_ptr advances on pop.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, and both pointers advance.
- Empty boundary: pop cannot occur. A simultaneous push is accepted normally.
- Full boundary: push cannot occur. A pop proceeds, and in_ready rises in the following cycle.
- Flush (synchronous, highest priority):
  - Next state: count = 0, rd_ptr = wr_ptr = 0, out_valid = 0.
  - A push and a pop presented in the flush cycle are both discarded.
  - in_ready remains as computed from the pre-flush count in the flush cycle.
- Reset mid-operation: state returns immediately to reset values regardless of pending handshakes. The first push after rst deasserts is accepted normally.
- Backpressure stability: when out_valid=1 and out_ready=0, out_instr and out_pc hold stable until a pop or a flush.
- No state machine is required beyond the pointer/count datapath.

Decomposition:
- Shared package cpu_pkg holds:
  - default DATA_WIDTH / ADDR_WIDTH localparams.
  - NOP_WORD constant.
  - a ptr_width(depth) helper wrapping $clog2.
- One natural sub-module, iq_storage:
  - DEPTH x (DATA_WIDTH+ADDR_WIDTH) register array.
  - Synchronous write port and asynchronous read port.
  - No reset on the array.
- Top level keeps pointers, count, flush and handshake logic.

Test Plan:
- Reset while words are held, then push 0x8C220004 @ PC 0x00400000 → next cycle out_valid=1, out_instr=0x8C220004, out_pc=0x00400000, count=1.
- Fill with out_ready=0: push 4 words (PCs 0x0,0x4,0x8,0xC) → in_ready=0 after the 4th, count=4. A 5th push attempt is refused, and the head remains PC 0x0.
- Full, then out_ready=1 with in_valid=1 for one cycle → the pop occurs and the push is refused, count=3, in_ready=1 the following cycle, head = PC 0x4.
- Streaming: in_valid=out_ready=1 for 10 cycles with incrementing PCs → count stays at 1, outputs appear in PC order with one-cycle latency, and the pointers wrap past DEPTH with no loss or reordering.
- Flush with count=3 plus a simultaneous push and pop → next cycle count=0, out_valid=0, out_instr=NOP_WORD. The pushed word never appears.
- rst pulse asynchronously mid-cycle with count=2 → outputs go to reset values before the next clk edge.
